// File: rtl/dmem_responder.sv
// Data-memory responder: DEPTH x 64-bit byte-lane array behind valid/ready request/response channels.
// Define DMEM_B2B_EN to accept a new request on the same edge a response handshakes (1 request/cycle).
module dmem_responder #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 64
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [63:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [63:0]       rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {IDLE, RESP} state_t;

  state_t           state;
  logic [63:0]      mem [DEPTH];
  logic             accept;
  logic             out_of_range;
  logic             misaligned;
  logic             bad_funct3;
  logic             err;
  logic [IDX_W-1:0] idx;
  logic [2:0]       lane;
  logic [5:0]       shamt;
  logic [63:0]      word;
  logic [63:0]      shifted;
  logic [63:0]      load_data;
  logic [63:0]      wdata_sh;
  logic [7:0]       size_mask;
  logic [7:0]       byte_en;

`ifdef DMEM_B2B_EN
  assign req_ready_o = reset_i & ((state == IDLE) | rsp_ready_i);
`else
  assign req_ready_o = reset_i & (state == IDLE);
`endif

  assign accept       = req_valid_i & req_ready_o;
  assign idx          = req_addr_i[3 +: IDX_W];
  assign lane         = req_addr_i[2:0];
  assign shamt        = {lane, 3'b000};
  assign out_of_range = |req_addr_i[ADDR_W-1:IDX_W+3];
  assign bad_funct3   = req_we_i ? req_funct3_i[2] : (req_funct3_i == 3'b111);
  assign err          = out_of_range | misaligned | bad_funct3;
  assign word         = mem[idx];
  assign shifted      = word >> shamt;
  assign byte_en      = size_mask << lane;
  assign wdata_sh     = req_wdata_i << shamt;

  // Access size comes from funct3[1:0] for both loads and stores.
  always_comb begin
    misaligned = 1'b0;
    size_mask  = 8'h01;
    case (req_funct3_i[1:0])
      2'b00: begin misaligned = 1'b0;      size_mask = 8'h01; end
      2'b01: begin misaligned = lane[0];   size_mask = 8'h03; end
      2'b10: begin misaligned = |lane[1:0]; size_mask = 8'h0F; end
      default: begin misaligned = |lane;   size_mask = 8'hFF; end
    endcase
  end

  always_comb begin
    load_data = '0;
    case (req_funct3_i)
      3'b000:  load_data = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  load_data = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  load_data = shifted;
      3'b100:  load_data = {56'b0, shifted[7:0]};
      3'b101:  load_data = {48'b0, shifted[15:0]};
      3'b110:  load_data = {32'b0, shifted[31:0]};
      default: load_data = '0;
    endcase
  end

  // The array has no reset so a store accepted before reset stays committed.
  always_ff @(posedge clk_i) begin
    if (accept && req_we_i && !err) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en[b]) mem[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state       <= IDLE;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else if (accept) begin
      state       <= RESP;
      rsp_valid_o <= 1'b1;
      rsp_rdata_o <= (err || req_we_i) ? 64'b0 : load_data;
      rsp_err_o   <= err;
    end else if (state == RESP && rsp_ready_i) begin
      state       <= IDLE;
      rsp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expectations, a monitor pops on each handshake.
// Throughput expectation follows DMEM_B2B_EN when the bench is built with it.
module tb_dmem_responder;

  localparam int DEPTH = 512;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_acc = 0;
  int   last_hs  = 0;
  int   first_acc;

  dmem_responder #(.DEPTH(DEPTH), .ADDR_W(64)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check_output(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%016h, want 0x%016h", name, act, exp);
    end
  endfunction

  // Monitor: a response that is valid and ready just before a rising edge handshakes on that edge.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (reset_i && rsp_valid && rsp_ready) begin
      last_hs = cyc + 1;
      if (sb.size() == 0) begin
        check_output("unexpected response", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check_output("rsp_rdata", rsp_rdata, e.rdata);
        check_output("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  task automatic apply_stimulus(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [63:0] exp_rdata,
                                input logic exp_err);
    logic seen;
    bit   done;
    done = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    sb.push_back({exp_rdata, exp_err});
    for (int t = 0; t < 40 && !done; t++) begin
      #1;
      seen = req_ready;
      if (seen) last_acc = cyc + 1;
      @(posedge clk);
      if (seen) done = 1;
      else @(negedge clk);
    end
    if (!done) check_output("accept timeout", 64'd0, 64'd1);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] exp_rdata, input logic exp_err);
    apply_stimulus(we, f3, addr, wdata, exp_rdata, exp_err);
    idle_bus();
  endtask

  task automatic wait_valid();
    bit got;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      #2;
      got = rsp_valid;
    end
    check_output("rsp_valid rise", 64'(got), 64'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && sb.size() != 0; t++) @(negedge clk);
    check_output("scoreboard drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_i    = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b0;

    #2;
    check_output("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check_output("reset req_ready", 64'(req_ready), 64'd0);
    check_output("reset rsp_rdata", rsp_rdata, 64'd0);
    check_output("reset rsp_err", 64'(rsp_err), 64'd0);
    #10 reset_i = 1'b1;
    #1 check_output("post-reset req_ready", 64'(req_ready), 64'd1);

    // Store held in RESP, then reset drops the response but keeps the write.
    issue(1'b1, 3'b011, 64'h10, 64'h8000_0000_FFFF_0001, 64'd0, 1'b0);
    wait_valid();
    #1 reset_i = 1'b0;
    #1;
    check_output("mid-resp reset rsp_valid", 64'(rsp_valid), 64'd0);
    check_output("mid-resp reset req_ready", 64'(req_ready), 64'd0);
    sb.delete();
    @(negedge clk) reset_i = 1'b1;
    #1 check_output("release req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    #2 check_output("no rsp after reset", 64'(rsp_valid), 64'd0);
    #1 rsp_ready = 1'b1;

    issue(1'b0, 3'b010, 64'h14, 64'h0, 64'hFFFF_FFFF_8000_0000, 1'b0);
    issue(1'b0, 3'b110, 64'h14, 64'h0, 64'h0000_0000_8000_0000, 1'b0);
    issue(1'b0, 3'b100, 64'h10, 64'h0, 64'h0000_0000_0000_0001, 1'b0);
    issue(1'b0, 3'b011, 64'h10, 64'h0, 64'h8000_0000_FFFF_0001, 1'b0);
    issue(1'b0, 3'b001, 64'h12, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    issue(1'b0, 3'b101, 64'h12, 64'h0, 64'h0000_0000_0000_FFFF, 1'b0);
    issue(1'b0, 3'b000, 64'h17, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);

    issue(1'b1, 3'b011, 64'h20, 64'h0, 64'd0, 1'b0);
    issue(1'b1, 3'b000, 64'h23, 64'h1122_3344_5566_77AB, 64'd0, 1'b0);
    issue(1'b1, 3'b001, 64'h26, 64'hDEAD_BEEF_CAFE_1234, 64'd0, 1'b0);
    issue(1'b0, 3'b011, 64'h20, 64'h0, 64'h1234_0000_AB00_0000, 1'b0);
    issue(1'b0, 3'b000, 64'h23, 64'h0, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0);
    issue(1'b0, 3'b001, 64'h26, 64'h0, 64'h0000_0000_0000_1234, 1'b0);

    issue(1'b0, 3'b001, 64'h101, 64'h0, 64'd0, 1'b1);
    issue(1'b1, 3'b010, 64'h22, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    issue(1'b1, 3'b100, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    issue(1'b0, 3'b011, 64'h20, 64'h0, 64'h1234_0000_AB00_0000, 1'b0);
    issue(1'b0, 3'b011, 64'(DEPTH * 8), 64'h0, 64'd0, 1'b1);
    issue(1'b0, 3'b011, 64'h8000_0000_0000_0000, 64'h0, 64'd0, 1'b1);
    issue(1'b0, 3'b111, 64'h20, 64'h0, 64'd0, 1'b1);
    issue(1'b1, 3'b011, 64'(DEPTH * 8 - 8), 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0);
    issue(1'b0, 3'b011, 64'(DEPTH * 8 - 8), 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0);
    drain();

    // Backpressure: response must hold while a pending store on the inputs is ignored.
    @(negedge clk) rsp_ready = 1'b0;
    issue(1'b0, 3'b011, 64'h10, 64'h0, 64'h8000_0000_FFFF_0001, 1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b011;
      req_addr   = 64'h10;
      req_wdata  = 64'(i) * 64'h1111_1111;
      #2;
      check_output("stall rsp_valid", 64'(rsp_valid), 64'd1);
      check_output("stall rsp_rdata", rsp_rdata, 64'h8000_0000_FFFF_0001);
      check_output("stall req_ready", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    issue(1'b0, 3'b011, 64'h10, 64'h0, 64'h8000_0000_FFFF_0001, 1'b0);

    for (int i = 0; i < 8; i++)
      issue(1'b1, 3'b011, 64'h40 + 64'(i * 8), {8{8'(i + 1)}}, 64'd0, 1'b0);
    drain();
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, 3'b011, 64'h40 + 64'(i * 8), 64'h0, {8{8'(i + 1)}}, 1'b0);
      if (i == 0) first_acc = last_acc;
    end
    idle_bus();
    drain();
`ifdef DMEM_B2B_EN
    check_output("burst cycles", 64'(last_hs - first_acc + 1), 64'd9);
`else
    check_output("burst cycles", 64'(last_hs - first_acc + 1), 64'd16);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
